data_to_time: RTL
=================

DATA_TO_TIME -- requirements
Module: data_to_time

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning received byte width.
REQ-002 The block SHALL have parameter TIMEOUT_TICKS, default 100, meaning the number of tick_100hz pulses allowed between bytes of a frame (1 s).
REQ-003 The block SHALL have port clk  input  1  system clock; all logic is on the rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port rx_data  input  DATA_WIDTH  received ASCII byte, valid only while rx_done=1.
REQ-006 The block SHALL have port rx_done  input  1  single-cycle strobe, one per received byte.
REQ-007 The block SHALL have port tick_100hz  input  1  single-cycle 100 Hz timebase strobe.
REQ-008 The block SHALL have port sw_mode  output  1  decoded mode: 1 = clock ("CL"), 0 = stopwatch ("SW").
REQ-009 The block SHALL have ports hour1, hour0, min1, min0, sec1, sec0  output  4 each  decoded BCD time digits.
REQ-010 The block SHALL have port time_valid  output  1  one-cycle pulse when a complete, valid frame has been decoded.
REQ-011 The block SHALL have port frame_err  output  1  one-cycle pulse when a frame is aborted.

Function
REQ-012 The accepted frame SHALL be exactly 12 bytes: idx0 'C'|'S', idx1 'L'|'W', idx2 0x20, idx3-4 hour digits, idx5 0x3A, idx6-7 minute digits, idx8 0x3A, idx9-10 second digits, idx11 0x0A.
REQ-013 idx1 SHALL pair with idx0: 'C' requires 'L' and 'S' requires 'W'; any other pairing is a mismatch.
REQ-014 Digit positions SHALL accept only 0x30-0x39; the stored value SHALL be rx_data[3:0].
REQ-015 The FSM SHALL have the states IDLE (waiting for idx0), RECV (idx1..idx11, tracked by a 4-bit index counter), and DONE (one cycle, drives the output update).
REQ-016 A byte of 0x0D (CR) SHALL be ignored in every state; it neither advances the index nor resets the timeout.
REQ-017 In IDLE, 'C' or 'S' SHALL latch the staged mode, set index=1, and enter RECV; any other byte SHALL be dropped silently with no frame_err.
REQ-018 In RECV, a matching byte SHALL be stored into the staging registers and SHALL increment the index.
REQ-019 A matching 0x0A at idx11 SHALL enter DONE.
REQ-020 In RECV, a mismatching byte SHALL pulse frame_err on the next cycle and SHALL discard the staging registers.
REQ-021 After such a mismatch, if the byte is 'C' or 'S' it SHALL start a new frame at index=1; otherwise the FSM SHALL return to IDLE.
REQ-022 Range check at idx11: hour SHALL be <=23, minutes SHALL be <=59, and seconds SHALL be <=59 (tens digit <=5, and hour1 <=2 with hour0 <=3 when hour1=2).
REQ-023 A range-check failure SHALL pulse frame_err and return to IDLE; the outputs SHALL be unchanged.
REQ-024 Timeout: in RECV, a counter SHALL count tick_100hz pulses and SHALL clear on every accepted byte.
REQ-025 When the timeout counter reaches TIMEOUT_TICKS, the block SHALL pulse frame_err and return to IDLE.
REQ-026 If rx_done and the timeout expiry coincide, the byte SHALL take priority and the timeout SHALL NOT fire.
REQ-027 In DONE, sw_mode and all six digit outputs SHALL load from the staging registers together, time_valid SHALL be 1 for exactly that cycle, and the FSM SHALL go to IDLE.
REQ-028 Latency: time_valid SHALL assert on the cycle after the clk edge that samples rx_done with 0x0A.
REQ-029 An rx_done arriving during DONE SHALL be processed as an IDLE-state byte.
REQ-030 The outputs SHALL change only in DONE; they hold their values indefinitely otherwise.
REQ-031 time_valid and frame_err SHALL never assert in the same cycle.

Reset
REQ-032 On rst, the FSM SHALL go to IDLE, with index=0 and timeout=0.
REQ-033 On rst, all digit outputs and sw_mode SHALL be 0, and time_valid and frame_err SHALL be 0.
REQ-034 Reset asserted mid-frame SHALL discard the partial frame with no frame_err pulse.

Verification
REQ-035 Bytes "CL 12:34:56\n" -> a single time_valid pulse; sw_mode=1, hour=1/2, min=3/4, sec=5/6.
REQ-036 Bytes "SW 23:59:59\r\n" -> time_valid; sw_mode=0, digits 2,3,5,9,5,9 (CR ignored).
REQ-037 Bytes "CL 24:00:00\n" -> frame_err at LF; outputs keep their prior values; no time_valid.
REQ-038 Bytes "CL 1S", then "W 01:02:03\n" -> frame_err at 'S', then time_valid with sw_mode=0 and digits 0,1,0,2,0,3.
REQ-039 Bytes "CL 1", then TIMEOUT_TICKS tick_100hz pulses with no bytes -> exactly one frame_err; a following "CL 00:00:00\n" decodes normally.
REQ-040 rst pulsed after "CL 12:" -> outputs all 0; no frame_err; the next full frame decodes correctly.

Source files
------------

// File: rtl/data_to_time_if.sv
// Byte-stream input and decoded-time output bundle for data_to_time.
interface data_to_time_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_done;
    logic                  tick_100hz;
    logic                  sw_mode;
    logic [3:0]            hour1;
    logic [3:0]            hour0;
    logic [3:0]            min1;
    logic [3:0]            min0;
    logic [3:0]            sec1;
    logic [3:0]            sec0;
    logic                  time_valid;
    logic                  frame_err;

    modport master (
        output rx_data, rx_done, tick_100hz,
        input  sw_mode, hour1, hour0, min1, min0, sec1, sec0, time_valid, frame_err
    );

    modport slave (
        input  rx_data, rx_done, tick_100hz,
        output sw_mode, hour1, hour0, min1, min0, sec1, sec0, time_valid, frame_err
    );
endinterface

// File: rtl/data_to_time.sv
// Decodes a 12-byte ASCII frame "CL hh:mm:ss\n" / "SW hh:mm:ss\n" into BCD
// time digits and a mode bit, with per-byte format checks, a range check at
// the terminating LF and an inter-byte timeout driven by a 100 Hz tick.
module data_to_time #(
    parameter int DATA_WIDTH    = 8,
    parameter int TIMEOUT_TICKS = 100
) (
    input  logic          clk,
    input  logic          rst,
    data_to_time_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RECV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int TW = (TIMEOUT_TICKS < 2) ? 1 : $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_TICKS - 1);

    localparam logic [DATA_WIDTH-1:0] CH_C   = DATA_WIDTH'(8'h43);
    localparam logic [DATA_WIDTH-1:0] CH_S   = DATA_WIDTH'(8'h53);
    localparam logic [DATA_WIDTH-1:0] CH_L   = DATA_WIDTH'(8'h4C);
    localparam logic [DATA_WIDTH-1:0] CH_W   = DATA_WIDTH'(8'h57);
    localparam logic [DATA_WIDTH-1:0] CH_SP  = DATA_WIDTH'(8'h20);
    localparam logic [DATA_WIDTH-1:0] CH_COL = DATA_WIDTH'(8'h3A);
    localparam logic [DATA_WIDTH-1:0] CH_LF  = DATA_WIDTH'(8'h0A);
    localparam logic [DATA_WIDTH-1:0] CH_CR  = DATA_WIDTH'(8'h0D);
    localparam logic [DATA_WIDTH-1:0] CH_0   = DATA_WIDTH'(8'h30);
    localparam logic [DATA_WIDTH-1:0] CH_9   = DATA_WIDTH'(8'h39);

    // Digit slots, MSB first: [5]=hour1 [4]=hour0 [3]=min1 [2]=min0 [1]=sec1 [0]=sec0
    logic [1:0]       state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             mode_stg_q, mode_stg_d;
    logic [5:0][3:0]  stg_q, stg_d;
    logic             mode_q, mode_d;
    logic [5:0][3:0]  out_q, out_d;
    logic             time_valid_q, time_valid_d;
    logic             frame_err_q, frame_err_d;

    logic byte_v;
    logic is_start;
    logic is_digit;
    logic match;
    logic range_ok;

    // Classify the incoming byte and check it against the current frame position
    always_comb begin
        byte_v   = bus.rx_done && (bus.rx_data != CH_CR);
        is_start = (bus.rx_data == CH_C) || (bus.rx_data == CH_S);
        is_digit = (bus.rx_data >= CH_0) && (bus.rx_data <= CH_9);
        range_ok = (stg_q[5] <= 4'd2) && !((stg_q[5] == 4'd2) && (stg_q[4] > 4'd3)) &&
                   (stg_q[3] <= 4'd5) && (stg_q[1] <= 4'd5);
        match    = 1'b0;
        case (idx_q)
            4'd1:                         match = (bus.rx_data == (mode_stg_q ? CH_L : CH_W));
            4'd2:                         match = (bus.rx_data == CH_SP);
            4'd3, 4'd4, 4'd6, 4'd7,
            4'd9, 4'd10:                  match = is_digit;
            4'd5, 4'd8:                   match = (bus.rx_data == CH_COL);
            4'd11:                        match = (bus.rx_data == CH_LF);
            default:                      match = 1'b0;
        endcase
    end

    // Frame FSM: staging, timeout, output load and status pulses
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        tmo_d        = tmo_q;
        mode_stg_d   = mode_stg_q;
        stg_d        = stg_q;
        mode_d       = mode_q;
        out_d        = out_q;
        time_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state_q)
            ST_RECV: begin
                if (byte_v) begin
                    // A real byte always wins over a coincident timeout tick
                    tmo_d = '0;
                    if (match) begin
                        idx_d = idx_q + 4'd1;
                        case (idx_q)
                            4'd3:  stg_d[5] = bus.rx_data[3:0];
                            4'd4:  stg_d[4] = bus.rx_data[3:0];
                            4'd6:  stg_d[3] = bus.rx_data[3:0];
                            4'd7:  stg_d[2] = bus.rx_data[3:0];
                            4'd9:  stg_d[1] = bus.rx_data[3:0];
                            4'd10: stg_d[0] = bus.rx_data[3:0];
                            default: ;
                        endcase
                        if (idx_q == 4'd11) begin
                            idx_d = 4'd0;
                            if (range_ok) begin
                                state_d      = ST_DONE;
                                mode_d       = mode_stg_q;
                                out_d        = stg_q;
                                time_valid_d = 1'b1;
                            end else begin
                                state_d     = ST_IDLE;
                                frame_err_d = 1'b1;
                            end
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        stg_d       = '0;
                        mode_stg_d  = 1'b0;
                        if (is_start) begin
                            // The offending byte may itself begin the next frame
                            mode_stg_d = (bus.rx_data == CH_C);
                            idx_d      = 4'd1;
                        end else begin
                            state_d = ST_IDLE;
                            idx_d   = 4'd0;
                        end
                    end
                end else if (bus.tick_100hz) begin
                    if (tmo_q == TMO_LAST) begin
                        state_d     = ST_IDLE;
                        idx_d       = 4'd0;
                        tmo_d       = '0;
                        frame_err_d = 1'b1;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
            end
            default: begin
                // IDLE and DONE both hunt for a frame start
                state_d = ST_IDLE;
                idx_d   = 4'd0;
                tmo_d   = '0;
                if (byte_v && is_start) begin
                    state_d    = ST_RECV;
                    idx_d      = 4'd1;
                    mode_stg_d = (bus.rx_data == CH_C);
                end
            end
        endcase
    end

    // State registers, asynchronously cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= 4'd0;
            tmo_q        <= '0;
            mode_stg_q   <= 1'b0;
            stg_q        <= '0;
            mode_q       <= 1'b0;
            out_q        <= '0;
            time_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            tmo_q        <= tmo_d;
            mode_stg_q   <= mode_stg_d;
            stg_q        <= stg_d;
            mode_q       <= mode_d;
            out_q        <= out_d;
            time_valid_q <= time_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign bus.sw_mode    = mode_q;
    assign bus.hour1      = out_q[5];
    assign bus.hour0      = out_q[4];
    assign bus.min1       = out_q[3];
    assign bus.min0       = out_q[2];
    assign bus.sec1       = out_q[1];
    assign bus.sec0       = out_q[0];
    assign bus.time_valid = time_valid_q;
    assign bus.frame_err  = frame_err_q;
endmodule
